// File: rtl/ysyx_22050078_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU.
// One transaction in flight; the response is routed to its owner, and WAIT is bounded by TIMEOUT.
module ysyx_22050078_mem_arb #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_W-1:0]     ifu_rsp_data,
  output logic                  ifu_rsp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_W-1:0]     lsu_rsp_data,
  output logic                  lsu_rsp_err,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic                  m_wen,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wmask,
  input  logic                  m_rsp_valid,
  input  logic [DATA_W-1:0]     m_rsp_data,
  output logic                  spurious_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN    = (TIMEOUT > 0);

  state_t           state;
  logic             owner_lsu;
  logic             last_lsu;
  logic [CNT_W-1:0] cnt;

  logic grant_lsu, grant_ifu;
  logic timeout_hit, rsp_fire;

  // On a tie the requester that did not win last time gets the port.
  assign grant_lsu = (state == S_IDLE) && lsu_req_valid && !(ifu_req_valid && last_lsu);
  assign grant_ifu = (state == S_IDLE) && ifu_req_valid && !grant_lsu;

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign m_req_valid   = (state == S_REQ);

  assign timeout_hit = TO_EN && (cnt == CNT_LAST);
  assign rsp_fire    = (state == S_WAIT) && (m_rsp_valid || timeout_hit);

  // A real response always takes priority over an abort in the same cycle.
  assign ifu_rsp_valid = rsp_fire && !owner_lsu;
  assign ifu_rsp_err   = ifu_rsp_valid && !m_rsp_valid;
  assign ifu_rsp_data  = (ifu_rsp_valid && m_rsp_valid) ? m_rsp_data : '0;
  assign lsu_rsp_valid = rsp_fire && owner_lsu;
  assign lsu_rsp_err   = lsu_rsp_valid && !m_rsp_valid;
  assign lsu_rsp_data  = (lsu_rsp_valid && m_rsp_valid) ? m_rsp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner_lsu    <= 1'b0;
      last_lsu     <= 1'b0;
      cnt          <= '0;
      m_addr       <= '0;
      m_wen        <= 1'b0;
      m_wdata      <= '0;
      m_wmask      <= '0;
      spurious_err <= 1'b0;
    end else begin
      if (m_rsp_valid && (state != S_WAIT)) spurious_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (grant_lsu) begin
            m_addr    <= lsu_addr;
            m_wen     <= lsu_wen;
            m_wdata   <= lsu_wdata;
            m_wmask   <= lsu_wmask;
            owner_lsu <= 1'b1;
            last_lsu  <= 1'b1;
            state     <= S_REQ;
          end else if (grant_ifu) begin
            m_addr    <= ifu_addr;
            m_wen     <= 1'b0;
            m_wdata   <= '0;
            m_wmask   <= '0;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_req_ready) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (rsp_fire) state <= S_IDLE;
          else          cnt   <= cnt + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
